// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry, reset image, lock mask.
// Latency: n/a (package only).
// Backpressure: n/a.
package reg_file_mp_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_ADDR       = 4;
    localparam int DEF_RD_PORTS   = 2;
    localparam int DEF_NUM_EXPORT = 4;

    // Registers with a non-zero power-on value; every other register resets to 0.
    localparam int         RST_IDX_CTRL = 2;
    localparam int         RST_IDX_MODE = 3;
    localparam logic [7:0] RST_VAL_CTRL = 8'h81;
    localparam logic [7:0] RST_VAL_MODE = 8'h20;

    localparam logic [DEF_DEPTH*DEF_WIDTH-1:0] DEF_RST_VAL =
        (DEF_DEPTH*DEF_WIDTH)'({RST_VAL_MODE, RST_VAL_CTRL, 16'h0000});

    // Control/mode registers become read-only once the lock is set.
    localparam logic [DEF_DEPTH-1:0] DEF_WP_MASK = 16'h000C;

    // Outcome of the write request presented in the current cycle.
    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_ACCEPT    = 2'd1,
        WR_RANGE_ERR = 2'd2,
        WR_PROT_ERR  = 2'd3
    } wr_status_e;

    function automatic logic wr_status_is_err(input wr_status_e s);
        return (s == WR_RANGE_ERR) || (s == WR_PROT_ERR);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Controller-side bus of the register file: write port, RD_PORTS read ports, lock, status, export.
// Latency: n/a (wires only).
// Backpressure: none; every request is consumed in the cycle it is presented.
//   master : system controller (drives requests, receives read data / status / REGS export)
//   slave  : reg_file_mp
interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR       = DEF_ADDR,
    parameter int RD_PORTS   = DEF_RD_PORTS,
    parameter int NUM_EXPORT = DEF_NUM_EXPORT
);
    // write port
    logic                       wr_en;
    logic [ADDR-1:0]            wr_addr;
    logic [WIDTH-1:0]           wr_data;
    logic [WIDTH/8-1:0]         wr_strb;
    // read ports, port p occupies slice p of each flat bus
    logic [RD_PORTS-1:0]        rd_en;
    logic [RD_PORTS*ADDR-1:0]   rd_addr;
    logic [RD_PORTS*WIDTH-1:0]  rd_data;
    logic [RD_PORTS-1:0]        rd_data_vld;
    logic [RD_PORTS-1:0]        rd_err;
    // lock and status
    logic                       lock;
    logic                       wr_err;
    logic                       locked;
    // live view of the exported registers
    logic [NUM_EXPORT*WIDTH-1:0] regs;

    modport master (
        output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr, lock,
        input  rd_data, rd_data_vld, rd_err, wr_err, locked, regs
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr, lock,
        output rd_data, rd_data_vld, rd_err, wr_err, locked, regs
    );

endinterface

// File: rtl/reg_file_mp_rd_port.sv
// One registered read port: range check on the address, captures data/valid/error.
// Latency: 1 cycle from rd_en_i to rd_vld_o.
// Backpressure: none; a read is accepted every cycle rd_en_i is high.
//   clk_i, rst_i      clock, async active-high reset
//   rd_en_i/rd_addr_i read request and address
//   rd_dat_i          array word already selected by the top for rd_addr_i
//   rd_data_o/rd_vld_o/rd_err_o  registered response
module reg_file_mp_rd_port
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR  = DEF_ADDR
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_en_i,
    input  logic [ADDR-1:0]  rd_addr_i,
    input  logic [WIDTH-1:0] rd_dat_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_vld_o,
    output logic             rd_err_o
);

    logic             in_range;
    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;

    // One extra bit so DEPTH == 2**ADDR does not wrap to zero.
    assign in_range = ({1'b0, rd_addr_i} < (ADDR+1)'(DEPTH));

    // Data and error hold their last value while the port is idle.
    always_comb begin
        data_d = data_q;
        err_d  = err_q;
        vld_d  = rd_en_i;
        if (rd_en_i) begin
            data_d = in_range ? rd_dat_i : '0;
            err_d  = !in_range;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    assign rd_data_o = data_q;
    assign rd_vld_o  = vld_q;
    assign rd_err_o  = err_q;

endmodule

// File: rtl/reg_file_mp.sv
// Config register store: byte-strobed write port, RD_PORTS registered read ports, sticky lock, REGS export.
// Latency: write visible 1 cycle after the write edge; reads return data 1 cycle after rd_en.
// Backpressure: none; rejected writes are reported by a 1-cycle wr_err pulse instead of stalling.
//   clk_i, rst_i  clock, async active-high reset (loads RST_VAL, clears lock and all flags)
//   bus           reg_file_mp_if.slave: write/read requests, lock, read responses, wr_err, locked, regs
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int                     WIDTH      = DEF_WIDTH,
    parameter int                     DEPTH      = DEF_DEPTH,
    parameter int                     ADDR       = DEF_ADDR,
    parameter int                     RD_PORTS   = DEF_RD_PORTS,
    parameter int                     NUM_EXPORT = DEF_NUM_EXPORT,
    parameter logic [DEPTH*WIDTH-1:0] RST_VAL    = (DEPTH*WIDTH)'(DEF_RST_VAL),
    parameter logic [DEPTH-1:0]       WP_MASK    = DEPTH'(DEF_WP_MASK)
)(
    input  logic          clk_i,
    input  logic          rst_i,
    reg_file_mp_if.slave  bus
);

    localparam int NB    = WIDTH / 8;
    localparam int ASPAN = 2 ** ADDR;
    // Mask widened to the full address space so it can be indexed by any address.
    localparam logic [ASPAN-1:0] WP_EXT = ASPAN'(WP_MASK);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             locked_q, locked_d;
    logic             wr_err_q, wr_err_d;
    wr_status_e       wr_status;
    logic             wr_in_range;

    logic [RD_PORTS*WIDTH-1:0]   rd_mux_dat;
    logic [RD_PORTS*WIDTH-1:0]   rd_data_w;
    logic [RD_PORTS-1:0]         rd_vld_w;
    logic [RD_PORTS-1:0]         rd_err_w;
    logic [NUM_EXPORT*WIDTH-1:0] regs_w;

    assign wr_in_range = ({1'b0, bus.wr_addr} < (ADDR+1)'(DEPTH));

    // Protection uses the registered lock, so a write arriving with the
    // first lock request is still judged as unlocked.
    always_comb begin
        wr_status = WR_IDLE;
        if (bus.wr_en) begin
            if (!wr_in_range) begin
                wr_status = WR_RANGE_ERR;
            end else if (locked_q && WP_EXT[bus.wr_addr]) begin
                wr_status = WR_PROT_ERR;
            end else begin
                wr_status = WR_ACCEPT;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_status == WR_ACCEPT && bus.wr_addr == ADDR'(i)) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wr_strb[b]) begin
                        mem_d[i][b*8 +: 8] = bus.wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign wr_err_d = wr_status_is_err(wr_status);
    assign locked_d = locked_q | bus.lock;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL[i*WIDTH +: WIDTH];
            end
            locked_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            locked_q <= locked_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Read mux works off the registered array, which gives read-before-write
    // on a same-cycle write. Out-of-range addresses match nothing and read 0.
    always_comb begin
        rd_mux_dat = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.rd_addr[p*ADDR +: ADDR] == ADDR'(i)) begin
                    rd_mux_dat[p*WIDTH +: WIDTH] = mem_q[i];
                end
            end
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        reg_file_mp_rd_port #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ADDR  (ADDR)
        ) u_rd_port (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .rd_en_i   (bus.rd_en[p]),
            .rd_addr_i (bus.rd_addr[p*ADDR +: ADDR]),
            .rd_dat_i  (rd_mux_dat[p*WIDTH +: WIDTH]),
            .rd_data_o (rd_data_w[p*WIDTH +: WIDTH]),
            .rd_vld_o  (rd_vld_w[p]),
            .rd_err_o  (rd_err_w[p])
        );
    end

    always_comb begin
        regs_w = '0;
        for (int i = 0; i < NUM_EXPORT; i++) begin
            regs_w[i*WIDTH +: WIDTH] = mem_q[i];
        end
    end

    assign bus.rd_data     = rd_data_w;
    assign bus.rd_data_vld = rd_vld_w;
    assign bus.rd_err      = rd_err_w;
    assign bus.wr_err      = wr_err_q;
    assign bus.locked      = locked_q;
    assign bus.regs        = regs_w;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default 8-bit/16-deep instance plus a 16-bit/12-deep instance.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 time unit after the next posedge.
// Backpressure: n/a.
module tb_reg_file_mp;
    import reg_file_mp_pkg::*;

    localparam int BW = 16;
    localparam int BD = 12;
    localparam int BA = 4;
    localparam int BP = 2;
    localparam int BE = 4;
    localparam logic [BD*BW-1:0] B_RST = {128'h0, 16'h2000, 16'h0081, 16'hABCD, 16'h1234};
    localparam logic [BD-1:0]    B_WP  = 12'h00C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_mp_if #(.WIDTH(8),  .ADDR(4),  .RD_PORTS(2),  .NUM_EXPORT(4))  ifa ();
    reg_file_mp_if #(.WIDTH(BW), .ADDR(BA), .RD_PORTS(BP), .NUM_EXPORT(BE)) ifb ();

    reg_file_mp #(
        .WIDTH(8), .DEPTH(16), .ADDR(4), .RD_PORTS(2), .NUM_EXPORT(4)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifa)
    );

    reg_file_mp #(
        .WIDTH(BW), .DEPTH(BD), .ADDR(BA), .RD_PORTS(BP), .NUM_EXPORT(BE),
        .RST_VAL(B_RST), .WP_MASK(B_WP)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifb)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.wr_strb = '0;
        ifa.rd_en = '0;   ifa.rd_addr = '0; ifa.lock = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.wr_strb = '0;
        ifb.rd_en = '0;   ifb.rd_addr = '0; ifb.lock = 1'b0;
    endtask

    // Reference model for instance B
    logic [BW-1:0] m_mem  [BD];
    logic          m_locked;
    logic [BW-1:0] m_last [BP];

    initial begin
        idle_all();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // ---- reset state ----
        check("a_rst_regs",   64'(ifa.regs), 64'h2081_0000);
        check("a_rst_vld",    64'(ifa.rd_data_vld), 64'h0);
        check("a_rst_err",    64'(ifa.rd_err), 64'h0);
        check("a_rst_wrerr",  64'(ifa.wr_err), 64'h0);
        check("a_rst_locked", 64'(ifa.locked), 64'h0);
        check("a_rst_rddata", 64'(ifa.rd_data), 64'h0);
        check("b_rst_regs",   64'(ifb.regs), 64'h2000_0081_ABCD_1234);
        rst = 1'b0;

        // ---- write then read on port 0 ----
        ifa.wr_en = 1'b1; ifa.wr_addr = 4'd5; ifa.wr_data = 8'hA5; ifa.wr_strb = 1'b1;
        step();
        check("a_wr5_noerr", 64'(ifa.wr_err), 64'h0);
        ifa.wr_en = 1'b0;
        ifa.rd_en = 2'b01; ifa.rd_addr = {4'd0, 4'd5};
        step();
        check("a_rd5_data", 64'(ifa.rd_data[7:0]), 64'hA5);
        check("a_rd5_vld",  64'(ifa.rd_data_vld), 64'h1);
        ifa.rd_en = 2'b00;
        step();
        check("a_rd5_vld_drop", 64'(ifa.rd_data_vld), 64'h0);
        check("a_rd5_hold",     64'(ifa.rd_data[7:0]), 64'hA5);

        // ---- same-cycle write and dual read: old data first ----
        ifa.wr_en = 1'b1; ifa.wr_addr = 4'd7; ifa.wr_data = 8'h3C; ifa.wr_strb = 1'b1;
        ifa.rd_en = 2'b11; ifa.rd_addr = {4'd7, 4'd7};
        step();
        check("a_rbw_old",  64'(ifa.rd_data), 64'h0000);
        check("a_rbw_vld",  64'(ifa.rd_data_vld), 64'h3);
        ifa.wr_en = 1'b0;
        step();
        check("a_rbw_new",  64'(ifa.rd_data), 64'h3C3C);
        check("a_b2b_vld",  64'(ifa.rd_data_vld), 64'h3);
        ifa.rd_en = 2'b00;

        // ---- lock protection ----
        ifa.lock = 1'b1;
        step();
        ifa.lock = 1'b0;
        check("a_locked", 64'(ifa.locked), 64'h1);
        ifa.wr_en = 1'b1; ifa.wr_addr = 4'd2; ifa.wr_data = 8'hFF;
        step();
        check("a_prot_wrerr", 64'(ifa.wr_err), 64'h1);
        ifa.wr_en = 1'b0;
        step();
        check("a_prot_pulse", 64'(ifa.wr_err), 64'h0);
        check("a_prot_keep",  64'(ifa.regs), 64'h2081_0000);
        ifa.wr_en = 1'b1; ifa.wr_addr = 4'd4; ifa.wr_data = 8'h77;
        step();
        check("a_unprot_noerr", 64'(ifa.wr_err), 64'h0);
        ifa.wr_en = 1'b0;
        ifa.rd_en = 2'b10; ifa.rd_addr = {4'd4, 4'd0};
        step();
        check("a_unprot_rd",  64'(ifa.rd_data[15:8]), 64'h77);
        check("a_unprot_vld", 64'(ifa.rd_data_vld), 64'h2);
        ifa.rd_en = 2'b00;

        // ---- instance B: write together with first lock is still allowed ----
        ifb.lock = 1'b1;
        ifb.wr_en = 1'b1; ifb.wr_addr = 4'd2; ifb.wr_data = 16'h5555; ifb.wr_strb = 2'b11;
        step();
        check("b_lockwr_noerr", 64'(ifb.wr_err), 64'h0);
        check("b_lockwr_lock",  64'(ifb.locked), 64'h1);
        check("b_lockwr_regs",  64'(ifb.regs), 64'h2000_5555_ABCD_1234);
        ifb.lock = 1'b0;

        // ---- out-of-range write/read ----
        ifb.wr_addr = 4'd13; ifb.wr_data = 16'hFFFF;
        step();
        check("b_oor_wrerr", 64'(ifb.wr_err), 64'h1);
        check("b_oor_regs",  64'(ifb.regs), 64'h2000_5555_ABCD_1234);
        ifb.wr_en = 1'b0;
        ifb.rd_en = 2'b01; ifb.rd_addr = {4'd0, 4'd13};
        step();
        check("b_oor_rdata", 64'(ifb.rd_data[15:0]), 64'h0);
        check("b_oor_rderr", 64'(ifb.rd_err[0]), 64'h1);
        check("b_oor_vld",   64'(ifb.rd_data_vld), 64'h1);
        ifb.rd_en = 2'b00;

        // ---- upper-byte strobe only ----
        ifb.wr_en = 1'b1; ifb.wr_addr = 4'd0; ifb.wr_data = 16'hBEEF; ifb.wr_strb = 2'b10;
        step();
        check("b_strb_hi", 64'(ifb.regs[15:0]), 64'hBE34);
        ifb.wr_en = 1'b0;

        // ---- reset drops an in-flight read response ----
        ifb.rd_en = 2'b01; ifb.rd_addr = {4'd0, 4'd1};
        step();
        check("b_pre_rst_vld", 64'(ifb.rd_data_vld), 64'h1);
        ifb.rd_en = 2'b00;
        rst = 1'b1;
        #1;
        check("b_in_rst_vld", 64'(ifb.rd_data_vld), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("b_post_rst_vld",  64'(ifb.rd_data_vld), 64'h0);
        check("b_post_rst_data", 64'(ifb.rd_data), 64'h0);
        check("b_post_rst_lock", 64'(ifb.locked), 64'h0);
        check("a_post_rst_lock", 64'(ifa.locked), 64'h0);
        check("a_post_rst_regs", 64'(ifa.regs), 64'h2081_0000);
        check("b_post_rst_regs", 64'(ifb.regs), 64'h2000_0081_ABCD_1234);

        // ---- randomized traffic on instance B against the model ----
        for (int i = 0; i < BD; i++) m_mem[i] = B_RST[i*BW +: BW];
        m_locked = 1'b0;
        for (int p = 0; p < BP; p++) m_last[p] = '0;

        for (int c = 0; c < 600; c++) begin
            logic          we, lk, exp_err;
            logic [BA-1:0] wa;
            logic [BW-1:0] wd;
            logic [1:0]    ws;
            logic [BP-1:0] re;
            logic [BA-1:0] ra [BP];
            logic [BP-1:0] exp_rerr;

            we = 1'($urandom_range(0, 1));
            wa = BA'($urandom_range(0, 15));
            wd = BW'($urandom);
            ws = 2'($urandom_range(0, 3));
            lk = ($urandom_range(0, 99) == 0);
            re = BP'($urandom_range(0, 3));
            for (int p = 0; p < BP; p++)
                ra[p] = ($urandom_range(0, 2) == 0) ? wa : BA'($urandom_range(0, 15));

            ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd; ifb.wr_strb = ws;
            ifb.lock = lk; ifb.rd_en = re; ifb.rd_addr = {ra[1], ra[0]};

            // Expected responses come from the contents before this edge.
            exp_err = 1'b0;
            if (we) begin
                if (int'(wa) >= BD) exp_err = 1'b1;
                else if (m_locked && B_WP[wa]) exp_err = 1'b1;
            end
            exp_rerr = '0;
            for (int p = 0; p < BP; p++) begin
                if (re[p]) begin
                    if (int'(ra[p]) < BD) begin
                        m_last[p] = m_mem[ra[p]];
                    end else begin
                        m_last[p] = '0;
                        exp_rerr[p] = 1'b1;
                    end
                end
            end
            if (we && !exp_err) begin
                for (int b = 0; b < BW/8; b++)
                    if (ws[b]) m_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (lk) m_locked = 1'b1;

            step();
            check("r_wrerr",  64'(ifb.wr_err), 64'(exp_err));
            check("r_locked", 64'(ifb.locked), 64'(m_locked));
            check("r_vld",    64'(ifb.rd_data_vld), 64'(re));
            for (int p = 0; p < BP; p++) begin
                check($sformatf("r_data_p%0d", p), 64'(ifb.rd_data[p*BW +: BW]), 64'(m_last[p]));
                if (re[p]) check($sformatf("r_err_p%0d", p), 64'(ifb.rd_err[p]), 64'(exp_rerr[p]));
            end
            check("r_regs", 64'(ifb.regs), {m_mem[3], m_mem[2], m_mem[1], m_mem[0]});
        end

        idle_all();
        step();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
